// File: rtl/pipelined_adder_pkg.sv
// Shared constants and the stage-record type for the pipelined adder.
// Holds the default WIDTH/STAGES and the per-stage register layout.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;
    // Upper bound on WIDTH; stage records are sized to it.
    localparam int MAX_WIDTH      = 64;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // One pipeline register: operands shift right as segments are
    // consumed, partial sum fills in from the bottom.
    typedef struct packed {
        logic  valid;
        logic  carry;
        word_t psum;
        word_t a_rem;
        word_t b_rem;
    } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// slave: adder side (in_valid,a,b,carry_in,out_ready in; rest out).
// master: producer/consumer side. overflow only with
// PIPELINED_ADDER_OVF_EN.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             overflow;
`endif

    modport slave (
        input  in_valid, a, b, carry_in, out_ready,
`ifdef PIPELINED_ADDER_OVF_EN
        output overflow,
`endif
        output in_ready, out_valid, sum, carry_out
    );

    modport master (
        output in_valid, a, b, carry_in, out_ready,
`ifdef PIPELINED_ADDER_OVF_EN
        input  overflow,
`endif
        input  in_ready, out_valid, sum, carry_out
    );

endinterface

// File: rtl/adder_segment.sv
// Combinational W-bit ripple add with carry in/out.
// Ports: a, b (W bits), cin -> s (W bits), cout.
module adder_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep pipelined adder: {carry_out,sum} = a + b + carry_in.
// Ports: clk, rst_n (async, active low), bus (pipelined_adder_if.slave).
// Optional signed overflow output: define PIPELINED_ADDER_OVF_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int SEG = (STAGES >= 1) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || (WIDTH % SEG) != 0 || SEG * STAGES != WIDTH
        || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must split evenly into STAGES");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   adv;

    // A stage may load when it is empty or its successor moves on.
    always_comb begin
        adv         = '0;
        adv[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld[k] || adv[k+1];
        end
    end

    assign bus.in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         src;
        stage_t         q;
        logic [SEG-1:0] seg_s;
        logic           seg_c;

        if (k == 0) begin : g_first
            assign src = '{valid: bus.in_valid,
                           carry: bus.carry_in,
                           psum:  '0,
                           a_rem: word_t'(bus.a),
                           b_rem: word_t'(bus.b)};
        end else begin : g_next
            assign src = g_stage[k-1].q;
        end

        adder_segment #(.W(SEG)) u_seg (
            .a    (src.a_rem[SEG-1:0]),
            .b    (src.b_rem[SEG-1:0]),
            .cin  (src.carry),
            .s    (seg_s),
            .cout (seg_c)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv[k]) begin
                q <= '{valid: src.valid,
                       carry: seg_c,
                       psum:  src.psum | (word_t'(seg_s) << (k * SEG)),
                       a_rem: src.a_rem >> SEG,
                       b_rem: src.b_rem >> SEG};
            end
        end

        assign vld[k] = q.valid;

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;
            // Carry into the MSB is recovered from the MSB operand and
            // sum bits; registered alongside the last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv[k]) begin
                    ovf_q <= src.a_rem[SEG-1] ^ src.b_rem[SEG-1]
                           ^ seg_s[SEG-1] ^ seg_c;
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].q.valid;
    assign bus.sum       = g_stage[STAGES-1].q.psum[WIDTH-1:0];
    assign bus.carry_out = g_stage[STAGES-1].q.carry;
`ifdef PIPELINED_ADDER_OVF_EN
    assign bus.overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4: number of pipeline segments, each adding WIDTH/STAGES bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port carry_in, input, 1 bit: carry into bit 0.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: the result {carry_out,sum} = a + b + carry_in.
REQ-013 The block SHALL have port carry_out, output, 1 bit: carry out of the MSB.
REQ-014 The block SHALL have port overflow, output, 1 bit, present only with PIPELINED_ADDER_OVF_EN: signed two's-complement overflow.

Function
REQ-015 An operand set SHALL transfer on a rising edge when in_valid=1 and in_ready=1; a result SHALL transfer when out_valid=1 and out_ready=1.
REQ-016 Stage k (0..STAGES-1) SHALL add operand bits [k*SEG +: SEG], SEG=WIDTH/STAGES, using the carry registered by stage k-1; stage 0 SHALL use carry_in.
REQ-017 Operand bits not yet consumed and sum bits already produced SHALL be carried forward in the stage registers with their valid bit.
REQ-018 Latency from input transfer to out_valid SHALL be exactly STAGES cycles when no stall occurs.
REQ-019 Throughput SHALL be one result per cycle while out_ready=1.
REQ-020 Each stage SHALL advance when it is empty or the next stage advances; the last stage SHALL advance when out_ready=1 or out_valid=0.
REQ-021 in_ready SHALL equal the stage-0 advance condition, combinationally, so bubbles are filled.
REQ-022 With out_valid=1 and out_ready=0, sum, carry_out and overflow SHALL hold stable; no result SHALL be lost or duplicated.
REQ-023 A simultaneous input transfer and output transfer on a full pipe SHALL both complete in the same cycle.
REQ-024 in_valid while in_ready=0 SHALL be ignored, and a, b and carry_in SHALL NOT be sampled.
REQ-025 The arithmetic SHALL be unsigned modulo 2^WIDTH, with carry_out as bit WIDTH; the output SHALL wrap without saturation.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid, sum, carry_out, overflow and all data registers to 0.
REQ-027 Reset mid-operation SHALL discard in-flight results, and no out_valid SHALL appear for pre-reset inputs.
REQ-028 in_ready SHALL be 1 from the first edge after rst_n deasserts.

Configuration
REQ-029 With PIPELINED_ADDER_OVF_EN defined, the overflow port SHALL exist and equal (carry into the MSB) XOR carry_out, aligned with sum.
REQ-030 Without PIPELINED_ADDER_OVF_EN, the overflow port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package pipelined_adder_pkg SHALL hold the default WIDTH and STAGES constants and the stage-record typedef (valid, carry, partial sum, remaining operands).
REQ-032 The sub-module adder_segment SHALL implement the combinational SEG-bit ripple add with carry in/out, instantiated once per stage.
REQ-033 The block SHALL check at elaboration that WIDTH mod STAGES = 0 and STAGES >= 1.

Verification
REQ-034 With WIDTH=16 and STAGES=4, a=0xFFFF, b=0x0001, carry_in=0 SHALL give sum=0x0000 and carry_out=1 exactly 4 cycles after the transfer.
REQ-035 Back-to-back inputs 1+1, 2+2 and 3+3 with out_ready=1 SHALL give results 2, 4 and 6 on consecutive cycles starting at cycle 4.
REQ-036 With out_ready=0 for 10 cycles and continuous in_valid, in_ready SHALL drop after 4 accepted inputs, sum SHALL stay stable, and out_ready=1 SHALL then drain all 4 in order.
REQ-037 rst_n pulsed low with 3 results in flight SHALL give out_valid=0 and sum=0 immediately, and no stale results SHALL follow.
REQ-038 With OVF_EN, 0x7FFF+0x0001 SHALL give overflow=1 and carry_out=0, and 0xFFFF+0x0001 SHALL give overflow=0 and carry_out=1.
REQ-039 a=0x1234, b=0x4321, carry_in=1 SHALL give sum=0x5556 and carry_out=0.
